// File: rtl/hex_syscall_responder.sv
// Responder for Hex SVC requests (exit / write byte / read byte). It owns the input byte FIFO,
// the output byte port and the exit status. Optional stats counters: define HEX_SYSCALL_STATS_EN.
module hex_syscall_responder #(
  parameter int IN_DEPTH = 16,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [7:0]        i_req_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_eof,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [7:0]        o_out_data,
  output logic              o_exit,
  output logic [7:0]        o_exit_code,
  output logic              o_result,
  output logic [15:0]       o_nwrites,
  output logic [15:0]       o_nreads
);
  // Every port pair *_valid/*_ready transfers one item on a rising edge where both are high;
  // a valid, once raised, holds its data stable until that transfer happens.
  localparam int AW = $clog2(IN_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = IN_DEPTH[AW:0];

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RESP, S_HALT} state_t;
  state_t state, state_nxt;

  logic [7:0]    mem [IN_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty, push, pop;
  logic          accept, out_hs, rsp_hs;

  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);
  assign o_in_ready = !fifo_full;
  assign push       = i_in_valid && !fifo_full;
  assign pop        = (state == S_READ) && !fifo_empty;

  assign o_req_ready = (state == S_IDLE);
  assign o_out_valid = (state == S_WRITE);
  assign o_rsp_valid = (state == S_RESP);
  assign accept      = i_req_valid && o_req_ready;
  assign out_hs      = o_out_valid && i_out_ready;
  assign rsp_hs      = o_rsp_valid && i_rsp_ready;
  assign o_result    = o_exit && (o_exit_code == 8'h00);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (i_req_op)
            2'd0:    state_nxt = S_HALT;
            2'd1:    state_nxt = S_WRITE;
            2'd2:    state_nxt = S_READ;
            default: state_nxt = S_RESP;
          endcase
        end
      end
      S_WRITE: if (out_hs) state_nxt = S_RESP;
      S_READ:  if (!fifo_empty || i_in_eof) state_nxt = S_RESP;
      S_RESP:  if (rsp_hs) state_nxt = S_IDLE;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response word and output byte are loaded on the edge that enters RESP / WRITE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out_data  <= 8'h00;
      o_rsp_data  <= '0;
      o_exit      <= 1'b0;
      o_exit_code <= 8'h00;
    end else begin
      if (accept) begin
        case (i_req_op)
          2'd0: begin
            o_exit      <= 1'b1;
            o_exit_code <= i_req_data;
          end
          2'd1:    o_out_data <= i_req_data;
          2'd3:    o_rsp_data <= {{(DATA_W-1){1'b1}}, 1'b0};
          default: ;
        endcase
      end
      if (out_hs) o_rsp_data <= '0;
      if (state == S_READ) begin
        if (!fifo_empty)   o_rsp_data <= {{(DATA_W-8){1'b0}}, mem[rd_ptr]};
        else if (i_in_eof) o_rsp_data <= '1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_in_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

`ifdef HEX_SYSCALL_STATS_EN
  logic [15:0] nwrites, nreads;
  // A pop only happens on a data-returning read, so it doubles as the read-count strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      nwrites <= 16'h0000;
      nreads  <= 16'h0000;
    end else begin
      if (out_hs && nwrites != 16'hFFFF) nwrites <= nwrites + 16'd1;
      if (pop && nreads != 16'hFFFF)     nreads  <= nreads + 16'd1;
    end
  end
  assign o_nwrites = nwrites;
  assign o_nreads  = nreads;
`else
  assign o_nwrites = 16'h0000;
  assign o_nreads  = 16'h0000;
`endif

endmodule
